dmem_ctrl: RTL and testbench

Data-memory controller between the processor's MEM-stage DMEM port and a word-wide, single-port synchronous SRAM with 1-cycle read latency and no byte enables. It handles big-endian byte, halfword and word loads with optional sign extension, performing lane extraction on reads. Sub-word stores use a read-modify-write sequence. It drives mem_stall, which holds the pipeline registers (ex_mem/mem_wb and upstream) while an access is in flight.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_lane_align.sv | 48 ++++
 rtl/dmem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, size decode and big-endian lane constants for dmem_ctrl
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_WAIT = 2'd1,
      RMW     = 2'd2
   } dmem_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } dmem_size_e;

   // Big-endian: offset 0 is the most significant lane of the word.
   localparam logic [1:0] BYTE_OFF_FIRST = 2'd0;
   localparam logic [1:0] BYTE_OFF_LAST  = 2'd3;
   localparam logic [1:0] HALF_OFF_FIRST = 2'd0;
   localparam logic [1:0] HALF_OFF_LAST  = 2'd2;

   function automatic dmem_size_e decode_size(input logic is_byte, input logic is_half);
      if (is_byte) return SZ_BYTE;
      if (is_half) return SZ_HALF;
      return SZ_WORD;
   endfunction

   function automatic logic is_misaligned(input dmem_size_e size, input logic [1:0] offset);
      case (size)
         SZ_HALF: return offset[0];
         SZ_WORD: return |offset;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - big-endian lane extract/extend for loads and lane merge for stores
module dmem_lane_align
   import dmem_pkg::*;
(
   input  dmem_size_e  size_i,
   input  logic [1:0]  offset_i,
   input  logic        sign_i,
   input  logic [31:0] rword_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [1:0]  byte_idx;
   logic [1:0]  half_idx;
   logic [4:0]  byte_lsb;
   logic [4:0]  half_lsb;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Lane index counted from the least significant end of the word.
   assign byte_idx = BYTE_OFF_LAST - offset_i;
   assign half_idx = HALF_OFF_LAST - {offset_i[1], 1'b0};
   assign byte_lsb = {byte_idx, 3'b000};
   assign half_lsb = {half_idx, 3'b000};
   assign lane_b   = rword_i[byte_lsb +: 8];
   assign lane_h   = rword_i[half_lsb +: 16];

   always_comb begin
      load_o  = 32'h0;
      merge_o = rword_i;
      case (size_i)
         SZ_BYTE: begin
            load_o = {{24{sign_i & lane_b[7]}}, lane_b};
            merge_o[byte_lsb +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            load_o = {{16{sign_i & lane_h[15]}}, lane_h};
            merge_o[half_lsb +: 16] = wdata_i[15:0];
         end
         default: begin
            load_o  = rword_i;
            merge_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - DMEM controller: big-endian sub-word loads, RMW stores, stall; DMEM_LOAD_BYPASS_EN adds a one-entry load buffer
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [0:31]       addr_from_proc,
   input  logic              read_enable_from_proc,
   input  logic              write_enable_from_proc,
   input  logic              byte_from_proc,
   input  logic              half_word_from_proc,
   input  logic              sign_extend_from_proc,
   input  logic [31:0]       data_from_proc,
   output logic [31:0]       data_to_proc,
   output logic              mem_stall,
   output logic              misalign_err,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_re,
   output logic              sram_we,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   dmem_state_e       state_q, state_d;
   dmem_size_e        size;
   logic [1:0]        offset;
   logic [ADDR_W-1:0] word_addr;
   logic              load_req, store_req, misaligned;
   logic              mis_set;
   logic              misalign_q, misalign_d;
   logic              bypass_hit;
   logic [31:0]       align_src, load_data, merge_data;
   logic              unused_addr_hi;

   assign size           = decode_size(byte_from_proc, half_word_from_proc);
   assign offset         = {addr_from_proc[30], addr_from_proc[31]};
   assign word_addr      = addr_from_proc[30-ADDR_W:29];
   assign store_req      = write_enable_from_proc;
   assign load_req       = read_enable_from_proc & ~write_enable_from_proc;
   assign misaligned     = is_misaligned(size, offset);
   assign unused_addr_hi = ^addr_from_proc[0:29-ADDR_W];
   assign sram_addr      = reset ? '0 : word_addr;

`ifdef DMEM_LOAD_BYPASS_EN
   logic              buf_valid_q, buf_valid_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [31:0]       buf_data_q, buf_data_d;

   assign bypass_hit = buf_valid_q && (buf_addr_q == word_addr);
   assign align_src  = (state_q == IDLE) ? buf_data_q : sram_rdata;

   // Keep the buffered word coherent with any store that writes it.
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      if (state_q == LD_WAIT) begin
         buf_valid_d = 1'b1;
         buf_addr_d  = word_addr;
         buf_data_d  = sram_rdata;
      end else if (sram_we && bypass_hit) begin
         buf_data_d = sram_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= 32'h0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
      end
   end
`else
   assign bypass_hit = 1'b0;
   assign align_src  = sram_rdata;
`endif

   dmem_lane_align u_align (
      .size_i   (size),
      .offset_i (offset),
      .sign_i   (sign_extend_from_proc),
      .rword_i  (align_src),
      .wdata_i  (data_from_proc),
      .load_o   (load_data),
      .merge_o  (merge_data)
   );

   always_comb begin
      state_d      = state_q;
      sram_re      = 1'b0;
      sram_we      = 1'b0;
      sram_wdata   = 32'h0;
      data_to_proc = 32'h0;
      mem_stall    = 1'b0;
      mis_set      = 1'b0;
      case (state_q)
         IDLE: begin
            if (store_req) begin
               if (misaligned) begin
                  mis_set = 1'b1;
               end else if (size == SZ_WORD) begin
                  sram_we    = 1'b1;
                  sram_wdata = data_from_proc;
               end else begin
                  sram_re   = 1'b1;
                  mem_stall = 1'b1;
                  state_d   = RMW;
               end
            end else if (load_req) begin
               if (misaligned) begin
                  mis_set = 1'b1;
               end else if (bypass_hit) begin
                  data_to_proc = load_data;
               end else begin
                  sram_re   = 1'b1;
                  mem_stall = 1'b1;
                  state_d   = LD_WAIT;
               end
            end
         end
         LD_WAIT: begin
            data_to_proc = load_data;
            state_d      = IDLE;
         end
         RMW: begin
            sram_we    = 1'b1;
            sram_wdata = merge_data;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A reset cycle must never let a strobe reach the SRAM, even mid-RMW.
      if (reset) begin
         state_d      = IDLE;
         sram_re      = 1'b0;
         sram_we      = 1'b0;
         sram_wdata   = 32'h0;
         data_to_proc = 32'h0;
         mem_stall    = 1'b0;
         mis_set      = 1'b0;
      end
   end

   assign misalign_d   = misalign_q | mis_set;
   assign misalign_err = ~reset & misalign_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         misalign_q <= misalign_d;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl with a behavioural SRAM
module tb_dmem_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        re_p, we_p, byte_p, half_p, sign_p;
   logic [31:0] wdata_p;
   logic [31:0] data_to_proc;
   logic        mem_stall, misalign_err;
   logic [9:0]  sram_addr;
   logic        sram_re, sram_we;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic [31:0] mem [0:1023];

   int          checks = 0;
   int          failures = 0;
   logic        tb_bv = 1'b0;
   logic [9:0]  tb_ba = '0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      if (sram_re) sram_rdata <= mem[sram_addr];
   end

   dmem_ctrl #(.ADDR_W(10)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .addr_from_proc         (addr),
      .read_enable_from_proc  (re_p),
      .write_enable_from_proc (we_p),
      .byte_from_proc         (byte_p),
      .half_word_from_proc    (half_p),
      .sign_extend_from_proc  (sign_p),
      .data_from_proc         (wdata_p),
      .data_to_proc           (data_to_proc),
      .mem_stall              (mem_stall),
      .misalign_err           (misalign_err),
      .sram_addr              (sram_addr),
      .sram_re                (sram_re),
      .sram_we                (sram_we),
      .sram_wdata             (sram_wdata),
      .sram_rdata             (sram_rdata)
   );

   task automatic drive(input logic r, input logic w, input logic b, input logic h,
                        input logic s, input logic [31:0] a, input logic [31:0] d);
      re_p = r; we_p = w; byte_p = b; half_p = h; sign_p = s; addr = a; wdata_p = d;
   endtask

   task automatic drive_idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic int exp_stall(input logic [31:0] a);
`ifdef DMEM_LOAD_BYPASS_EN
      return (tb_bv && tb_ba == a[11:2]) ? 0 : 1;
`else
      return (a[0] === 1'bx) ? 0 : 1;
`endif
   endfunction

   task automatic run_load(input logic [31:0] a, input logic b, input logic h, input logic s,
                           output logic [31:0] d, output int stalls);
      stalls = 0;
      d = 32'hx;
      drive(1'b1, 1'b0, b, h, s, a, 32'h0);
      for (int i = 0; i < 8; i++) begin
         #1;
         if (!mem_stall) begin
            d = data_to_proc;
            break;
         end
         stalls++;
         @(posedge clock);
      end
      if (stalls >= 8) stalls = -1;
      step();
      drive_idle();
      tb_bv = 1'b1;
      tb_ba = a[11:2];
   endtask

   task automatic run_store(input logic [31:0] a, input logic b, input logic h,
                            input logic [31:0] d, output int stalls);
      stalls = 0;
      drive(1'b0, 1'b1, b, h, 1'b0, a, d);
      for (int i = 0; i < 8; i++) begin
         #1;
         if (!mem_stall) break;
         stalls++;
         @(posedge clock);
      end
      if (stalls >= 8) stalls = -1;
      step();
      drive_idle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'h55);
      #1;
      checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
      checks++; if (sram_re !== 1'b0 || sram_we !== 1'b0) begin failures++; $display("FAIL reset_strobes got re=%b we=%b exp=0", sram_re, sram_we); end
      checks++; if (data_to_proc !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_to_proc); end
      checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
      checks++; if (sram_addr !== 10'h0 || sram_wdata !== 32'h0) begin failures++; $display("FAIL reset_addr_wdata got=%h/%h exp=0", sram_addr, sram_wdata); end
      step();
      step();
      reset = 1'b0;
      drive_idle();
      #1;
      checks++; if (mem_stall !== 1'b0 || sram_re !== 1'b0 || sram_we !== 1'b0 || data_to_proc !== 32'h0) begin
         failures++; $display("FAIL idle_outputs got stall=%b re=%b we=%b data=%h exp=0", mem_stall, sram_re, sram_we, data_to_proc); end
      tb_bv = 1'b0;
   endtask

   task automatic test_preload();
      int st;
      run_store(32'h100, 1'b0, 1'b0, 32'h8000FFEE, st);
      checks++; if (st !== 0) begin failures++; $display("FAIL preload_stall got=%0d exp=0", st); end
      run_store(32'h200, 1'b0, 1'b0, 32'h11223344, st);
      checks++; if (mem[10'h040] !== 32'h8000FFEE || mem[10'h080] !== 32'h11223344) begin
         failures++; $display("FAIL preload_mem got=%h/%h exp=8000ffee/11223344", mem[10'h040], mem[10'h080]); end
   endtask

   task automatic test_word_store();
      logic [31:0] d;
      int          st, es;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'hDEADBEEF);
      #1;
      checks++; if (sram_we !== 1'b1 || sram_re !== 1'b0 || mem_stall !== 1'b0) begin
         failures++; $display("FAIL wstore_strobes got we=%b re=%b stall=%b exp 1/0/0", sram_we, sram_re, mem_stall); end
      checks++; if (sram_wdata !== 32'hDEADBEEF || sram_addr !== 10'h0C0) begin
         failures++; $display("FAIL wstore_bus got wdata=%h addr=%h exp deadbeef/0c0", sram_wdata, sram_addr); end
      step();
      drive_idle();
      #1;
      checks++; if (mem[10'h0C0] !== 32'hDEADBEEF || sram_we !== 1'b0) begin
         failures++; $display("FAIL wstore_mem got=%h we=%b exp deadbeef/0", mem[10'h0C0], sram_we); end
      es = exp_stall(32'h300);
      run_load(32'h300, 1'b0, 1'b0, 1'b0, d, st);
      checks++; if (d !== 32'hDEADBEEF || st !== es) begin
         failures++; $display("FAIL wload_300 got data=%h stalls=%0d exp deadbeef/%0d", d, st, es); end
   endtask

   task automatic test_sub_loads();
      logic [31:0] ta [6] = '{32'h100, 32'h102, 32'h103, 32'h102, 32'h101, 32'h100};
      logic        tb [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        th [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic        ts [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] te [6] = '{32'hFFFFFF80, 32'h0000FFEE, 32'h000000EE,
                              32'hFFFFFFEE, 32'h00000000, 32'hFFFF8000};
      logic [31:0] d;
      int          st, es;
      for (int i = 0; i < 6; i++) begin
         es = exp_stall(ta[i]);
         run_load(ta[i], tb[i], th[i], ts[i], d, st);
         checks++; if (d !== te[i] || st !== es) begin
            failures++; $display("FAIL subload_%0d got data=%h stalls=%0d exp %h/%0d", i, d, st, te[i], es); end
      end
      #1;
      checks++; if (data_to_proc !== 32'h0 || mem_stall !== 1'b0) begin
         failures++; $display("FAIL subload_idle got data=%h stall=%b exp 0/0", data_to_proc, mem_stall); end
   endtask

   task automatic test_rmw();
      logic [31:0] d;
      int          st, es;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h202, 32'h123456AB);
      #1;
      checks++; if (sram_re !== 1'b1 || sram_we !== 1'b0 || mem_stall !== 1'b1) begin
         failures++; $display("FAIL rmw_read got re=%b we=%b stall=%b exp 1/0/1", sram_re, sram_we, mem_stall); end
      step();
      checks++; if (sram_we !== 1'b1 || sram_re !== 1'b0 || mem_stall !== 1'b0 || sram_wdata !== 32'h1122AB44) begin
         failures++; $display("FAIL rmw_write got we=%b re=%b stall=%b wdata=%h exp 1/0/0/1122ab44", sram_we, sram_re, mem_stall, sram_wdata); end
      step();
      drive_idle();
      checks++; if (mem[10'h080] !== 32'h1122AB44) begin failures++; $display("FAIL rmw_mem got=%h exp=1122ab44", mem[10'h080]); end
      es = exp_stall(32'h200);
      run_load(32'h200, 1'b0, 1'b0, 1'b0, d, st);
      checks++; if (d !== 32'h1122AB44 || st !== es) begin
         failures++; $display("FAIL rmw_load got data=%h stalls=%0d exp 1122ab44/%0d", d, st, es); end
      run_store(32'h302, 1'b0, 1'b1, 32'hFFFFCAFE, st);
      checks++; if (st !== 1 || mem[10'h0C0] !== 32'hDEADCAFE) begin
         failures++; $display("FAIL half_store got stalls=%0d mem=%h exp 1/deadcafe", st, mem[10'h0C0]); end
      run_store(32'h200, 1'b0, 1'b0, 32'h11223344, st);
   endtask

   task automatic test_misalign();
      checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL misalign_pre got=%b exp=0", misalign_err); end
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h101, 32'h0);
      #1;
      checks++; if (misalign_err !== 1'b1 || data_to_proc !== 32'h0) begin
         failures++; $display("FAIL misalign_load got err=%b data=%h exp 1/0", misalign_err, data_to_proc); end
      checks++; if (sram_re !== 1'b0 || sram_we !== 1'b0 || mem_stall !== 1'b0) begin
         failures++; $display("FAIL misalign_strobes got re=%b we=%b stall=%b exp 0/0/0", sram_re, sram_we, mem_stall); end
      step();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h302, 32'h0);
      #1;
      checks++; if (sram_we !== 1'b0 || mem_stall !== 1'b0) begin
         failures++; $display("FAIL misalign_store got we=%b stall=%b exp 0/0", sram_we, mem_stall); end
      step();
      drive_idle();
      #1;
      checks++; if (misalign_err !== 1'b1 || mem[10'h0C0] !== 32'hDEADCAFE) begin
         failures++; $display("FAIL misalign_sticky got err=%b mem=%h exp 1/deadcafe", misalign_err, mem[10'h0C0]); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%b exp=0", misalign_err); end
      tb_bv = 1'b0;
   endtask

   task automatic test_reset_mid_rmw();
      logic [31:0] d;
      int          st;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h000000AB);
      #1;
      checks++; if (sram_re !== 1'b1 || mem_stall !== 1'b1) begin
         failures++; $display("FAIL rstrmw_read got re=%b stall=%b exp 1/1", sram_re, mem_stall); end
      step();
      reset = 1'b1;
      #1;
      checks++; if (sram_we !== 1'b0 || mem_stall !== 1'b0) begin
         failures++; $display("FAIL rstrmw_we got we=%b stall=%b exp 0/0", sram_we, mem_stall); end
      step();
      reset = 1'b0;
      drive_idle();
      #1;
      checks++; if (mem[10'h080] !== 32'h11223344) begin failures++; $display("FAIL rstrmw_mem got=%h exp=11223344", mem[10'h080]); end
      tb_bv = 1'b0;
      run_load(32'h200, 1'b0, 1'b0, 1'b0, d, st);
      checks++; if (d !== 32'h11223344 || st !== 1) begin
         failures++; $display("FAIL rstrmw_idle got data=%h stalls=%0d exp 11223344/1", d, st); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int          st, es;
`ifdef DMEM_LOAD_BYPASS_EN
      int          hit_st = 0;
`else
      int          hit_st = 1;
`endif
      es = exp_stall(32'h100);
      run_load(32'h100, 1'b0, 1'b0, 1'b0, d, st);
      checks++; if (d !== 32'h8000FFEE || st !== es) begin
         failures++; $display("FAIL b2b_first got data=%h stalls=%0d exp 8000ffee/%0d", d, st, es); end
      run_load(32'h100, 1'b0, 1'b0, 1'b0, d, st);
      checks++; if (d !== 32'h8000FFEE || st !== hit_st) begin
         failures++; $display("FAIL b2b_second got data=%h stalls=%0d exp 8000ffee/%0d", d, st, hit_st); end
      run_store(32'h100, 1'b1, 1'b0, 32'h0000007F, st);
      checks++; if (st !== 1 || mem[10'h040] !== 32'h7F00FFEE) begin
         failures++; $display("FAIL b2b_store got stalls=%0d mem=%h exp 1/7f00ffee", st, mem[10'h040]); end
      run_load(32'h100, 1'b0, 1'b0, 1'b0, d, st);
      checks++; if (d !== 32'h7F00FFEE || st !== hit_st) begin
         failures++; $display("FAIL b2b_after_store got data=%h stalls=%0d exp 7f00ffee/%0d", d, st, hit_st); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit exceeded");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_preload();
      test_word_store();
      test_sub_loads();
      test_rmw();
      test_misalign();
      test_reset_mid_rmw();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
